bsg_axil_txs_scheduler: RTL and testbench
=========================================

Name: bsg_axil_txs_scheduler

Overview:
- Sits downstream of the AXI-Lite TX-slot write decoder.
- Collects per-slot 32-bit transmit words into fixed-size packets and round-robin arbitrates completed packets onto a single registered output towards the manycore link.
- Maintains per-slot vacancy counts (TDFV) and per-slot transmit-complete ISR bits, which the decoder clears.

Parameters:
- num_fifos_p, 2, number of TX slots; must be >= 1.
- words_per_pkt_p, 4, 32-bit words per packet (W); must be >= 1.
- Derived: src_width_lp = max(1, clog2(num_fifos_p)); vac_width_lp = clog2(W+1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- txs_i  in  num_fifos_p x 32  per-slot write data
- txs_v_i  in  num_fifos_p  per-slot word valid
- txs_ready_o  out  num_fifos_p  per-slot word ready
- pkt_o  out  W*32  packet; word 0 in bits [31:0]
- pkt_src_o  out  src_width_lp  slot index of pkt_o
- pkt_v_o  out  1  packet valid
- pkt_ready_i  in  1  downstream ready
- tdfv_o  out  num_fifos_p x vac_width_lp  per-slot vacancy in words
- isr_txc_o  out  num_fifos_p  per-slot transmit-complete status
- clr_isrs_txc_i  in  num_fifos_p  per-slot clear of the transmit-complete bit

Behaviour:
- One clock domain; reset is synchronous and active-high; all state changes on posedge clk_i.
- Per-slot state: cnt_r[i] (0..W) and buf_r[i] (W x 32).
  - txs_ready_o[i] = (cnt_r[i] < W), combinational from cnt_r only, with no dependency on txs_v_i.
  - Word accept when txs_v_i[i] & txs_ready_o[i]: buf_r[i][cnt_r[i]] <= txs_i[i]; cnt_r[i] <= cnt_r[i] + 1.
  - full[i] = (cnt_r[i] == W).
  - tdfv_o[i] = W - cnt_r[i].
- Output stage: registers out_v_r, out_data_r, out_src_r. pkt_v_o, pkt_o and pkt_src_o drive directly from these registers.
- Load enable: ld = (!out_v_r | pkt_ready_i) & (|full).
- Arbiter: round-robin over full[].
  - Search starts at last_r+1 and wraps modulo num_fifos_p; the first full slot is granted as g.
  - last_r updates to g only on ld.
- On ld:
  - out_data_r <= buf_r[g]; out_src_r <= g; out_v_r <= 1.
  - cnt_r[g] <= 0 in the same cycle.
  - Slot g cannot accept a word that cycle because its ready is low. It accepts again from the next cycle.
- Else, if out_v_r & pkt_ready_i: out_v_r <= 0.
- pkt_o and pkt_src_o hold stable while pkt_v_o=1 and pkt_ready_i=0. There are no bubbles: a new packet loads in the same cycle as the handshake if any slot is full.
- Latency: if the output stage is free, pkt_v_o rises 2 cycles after the handshake cycle of a packet's final word (cycle 1: full and grant; cycle 2: registered valid).
- Transmit-complete bit isr_txc_r[i]:
  - Set on an output handshake (pkt_v_o & pkt_ready_i & pkt_src_o==i).
  - Cleared on clr_isrs_txc_i[i].
  - Set and clear in the same cycle: set wins.
  - isr_txc_o = isr_txc_r, registered, visible the cycle after the event.
- W=1: a slot is full after every accepted word; the same rules apply.
- num_fifos_p=1: the arbiter degenerates to always granting slot 0, and pkt_src_o=0.
- Reset values:
  - cnt_r=0, so tdfv_o=W and txs_ready_o all 1.
  - out_v_r=0, out_data_r=0, out_src_r=0.
  - last_r = num_fifos_p-1, so slot 0 has first priority.
  - isr_txc_r=0.
- Reset mid-operation: partially assembled words and any pending output packet are discarded. buf_r contents are don't-care after reset, since they are never output unless cnt_r reaches W again.

Test Plan:
- Single packet (W=4, slot 0): words 0x11, 0x22, 0x33, 0x44 in consecutive cycles, pkt_ready_i=1.
  - tdfv_o[0] steps 4,3,2,1,0.
  - pkt_v_o is high 2 cycles after the 0x44 handshake with pkt_o=0x00000044_00000033_00000022_00000011 and pkt_src_o=0.
  - The following cycle tdfv_o[0]=4 and isr_txc_o[0]=1.
- Simultaneous full after reset: slots 0 and 1 complete in the same cycle.
  - Output order is slot 0 then slot 1, back-to-back with pkt_ready_i=1 and no idle cycle.
- Backpressure: pkt_ready_i=0 with slot 0's packet held on the output; slot 0 refills 4 words.
  - txs_ready_o[0]=0 and tdfv_o[0]=0; pkt_o stays unchanged.
  - Raising pkt_ready_i for one cycle: that cycle handshakes the first packet and loads the second.
- Fairness: slot 0 refills continuously and slot 1 is kept full.
  - pkt_src_o sequence alternates 0,1,0,1; neither slot is granted twice in a row while the other is full.
- ISR: clear alone gives isr_txc_o[i]=0 the next cycle; clear coincident with a slot-i handshake leaves isr_txc_o[i]=1.
- Reset mid-packet: reset with cnt_r[1]=2 and pkt_v_o=1.
  - The next cycle pkt_v_o=0, tdfv_o[1]=4 and isr_txc_o=0.
  - Subsequent 4 words produce a packet containing only the new words.

Source files
------------

// File: rtl/bsg_axil_txs_scheduler_if.sv
// Bundle of the TX-slot write side and the packet output side of the scheduler.
// master drives words and downstream ready; slave is the scheduler itself.
interface bsg_axil_txs_scheduler_if #(
    parameter int num_fifos_p     = 2,
    parameter int words_per_pkt_p = 4
);
    localparam int src_width_lp = (num_fifos_p > 1) ? $clog2(num_fifos_p) : 1;
    localparam int vac_width_lp = $clog2(words_per_pkt_p + 1);

    logic [num_fifos_p-1:0][31:0]           txs_i;
    logic [num_fifos_p-1:0]                 txs_v_i;
    logic [num_fifos_p-1:0]                 txs_ready_o;
    logic [words_per_pkt_p*32-1:0]          pkt_o;
    logic [src_width_lp-1:0]                pkt_src_o;
    logic                                   pkt_v_o;
    logic                                   pkt_ready_i;
    logic [num_fifos_p-1:0][vac_width_lp-1:0] tdfv_o;
    logic [num_fifos_p-1:0]                 isr_txc_o;
    logic [num_fifos_p-1:0]                 clr_isrs_txc_i;

    modport master (
        output txs_i, txs_v_i, pkt_ready_i, clr_isrs_txc_i,
        input  txs_ready_o, pkt_o, pkt_src_o, pkt_v_o, tdfv_o, isr_txc_o
    );

    modport slave (
        input  txs_i, txs_v_i, pkt_ready_i, clr_isrs_txc_i,
        output txs_ready_o, pkt_o, pkt_src_o, pkt_v_o, tdfv_o, isr_txc_o
    );
endinterface

// File: rtl/bsg_axil_txs_scheduler.sv
// Assembles per-slot words into fixed-size packets and round-robin arbitrates
// completed packets onto one registered output, with per-slot vacancy and TXC status.
module bsg_axil_txs_scheduler #(
    parameter int num_fifos_p     = 2,
    parameter int words_per_pkt_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_axil_txs_scheduler_if.slave       bus
);
    localparam int src_width_lp = (num_fifos_p > 1) ? $clog2(num_fifos_p) : 1;
    localparam int vac_width_lp = $clog2(words_per_pkt_p + 1);
    localparam int idx_width_lp = (words_per_pkt_p > 1) ? $clog2(words_per_pkt_p) : 1;
    localparam logic [vac_width_lp-1:0] w_lp         = vac_width_lp'(words_per_pkt_p);
    localparam logic [src_width_lp-1:0] last_init_lp = src_width_lp'(num_fifos_p - 1);

    logic [num_fifos_p-1:0][vac_width_lp-1:0]        cnt_r;
    logic [num_fifos_p-1:0][words_per_pkt_p-1:0][31:0] buf_r;
    logic [num_fifos_p-1:0]                          full;
    logic [num_fifos_p-1:0]                          ready;
    logic [num_fifos_p-1:0]                          accept;
    logic [num_fifos_p-1:0][vac_width_lp-1:0]        tdfv;

    logic                                 out_v_r;
    logic [words_per_pkt_p-1:0][31:0]     out_data_r;
    logic [src_width_lp-1:0]              out_src_r;
    logic [src_width_lp-1:0]              last_r;
    logic [src_width_lp-1:0]              grant;
    int                                   best;
    logic                                 ld;
    logic                                 hs;
    logic [num_fifos_p-1:0]               isr_txc_r;

    always_comb begin
        full   = '0;
        ready  = '0;
        accept = '0;
        tdfv   = '0;
        for (int i = 0; i < num_fifos_p; i++) begin
            full[i]   = (cnt_r[i] == w_lp);
            ready[i]  = (cnt_r[i] < w_lp);
            accept[i] = bus.txs_v_i[i] & ready[i];
            tdfv[i]   = w_lp - cnt_r[i];
        end
    end

    // Round-robin: pick the full slot with the smallest distance past last_r.
    always_comb begin
        grant = '0;
        best  = num_fifos_p;
        for (int s = 0; s < num_fifos_p; s++) begin
            if (full[s] && (((s + num_fifos_p - 1 - int'(last_r)) % num_fifos_p) < best)) begin
                best  = (s + num_fifos_p - 1 - int'(last_r)) % num_fifos_p;
                grant = src_width_lp'(s);
            end
        end
    end

    assign ld = (!out_v_r | bus.pkt_ready_i) & (|full);
    assign hs = out_v_r & bus.pkt_ready_i;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_fifos_p; i++) begin
            if (reset_i)
                cnt_r[i] <= '0;
            else if (ld && (grant == src_width_lp'(i)))
                cnt_r[i] <= '0;
            else if (accept[i])
                cnt_r[i] <= cnt_r[i] + vac_width_lp'(1);
        end
    end

    // Packet buffers need no reset: they are only read once cnt_r reaches W again.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_fifos_p; i++) begin
            if (accept[i])
                buf_r[i][cnt_r[i][idx_width_lp-1:0]] <= bus.txs_i[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_r    <= 1'b0;
            out_data_r <= '0;
            out_src_r  <= '0;
            last_r     <= last_init_lp;
        end else if (ld) begin
            out_v_r    <= 1'b1;
            out_data_r <= buf_r[grant];
            out_src_r  <= grant;
            last_r     <= grant;
        end else if (hs) begin
            out_v_r    <= 1'b0;
        end
    end

    // A handshake on slot i beats a simultaneous clear of that slot's bit.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_fifos_p; i++) begin
            if (reset_i)
                isr_txc_r[i] <= 1'b0;
            else if (hs && (out_src_r == src_width_lp'(i)))
                isr_txc_r[i] <= 1'b1;
            else if (bus.clr_isrs_txc_i[i])
                isr_txc_r[i] <= 1'b0;
        end
    end

    assign bus.txs_ready_o = ready;
    assign bus.tdfv_o      = tdfv;
    assign bus.pkt_v_o     = out_v_r;
    assign bus.pkt_o       = out_data_r;
    assign bus.pkt_src_o   = out_src_r;
    assign bus.isr_txc_o   = isr_txc_r;
endmodule

// File: tb/tb_bsg_axil_txs_scheduler.sv
// Bench for bsg_axil_txs_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based packet model.
module tb_bsg_axil_txs_scheduler;
    localparam int N  = 2;
    localparam int W  = 4;
    localparam int PW = W * 32;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bsg_axil_txs_scheduler_if #(.num_fifos_p(N), .words_per_pkt_p(W)) bus ();

    bsg_axil_txs_scheduler #(.num_fifos_p(N), .words_per_pkt_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   slot_q [N][$];
    logic          m_v;
    logic [PW-1:0] m_data;
    int            m_src;
    int            m_last;
    logic [N-1:0]  m_isr;

    task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) slot_q[i].delete();
        m_v    = 1'b0;
        m_data = '0;
        m_src  = 0;
        m_last = N - 1;
        m_isr  = '0;
    endtask

    task automatic checkAll();
        checkOutput("pkt_v", PW'(bus.pkt_v_o), PW'(m_v));
        checkOutput("pkt", bus.pkt_o, m_data);
        checkOutput("pkt_src", PW'(bus.pkt_src_o), PW'(m_src));
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("tdfv%0d", i), PW'(bus.tdfv_o[i]), PW'(W - slot_q[i].size()));
            checkOutput($sformatf("ready%0d", i), PW'(bus.txs_ready_o[i]), PW'(slot_q[i].size() < W));
            checkOutput($sformatf("isr%0d", i), PW'(bus.isr_txc_o[i]), PW'(m_isr[i]));
        end
    endtask

    // One clock: compute the model's next state from the current inputs, step, then compare.
    task automatic applyStimulus();
        logic [N-1:0]         full;
        logic [N-1:0]         nisr;
        logic [N-1:0]         v;
        logic [N-1:0][31:0]   d;
        bit                   hs;
        bit                   ld;
        int                   g;
        bit                   found;
        if (reset) begin
            @(posedge clk);
            modelReset();
        end else begin
            v = bus.txs_v_i;
            d = bus.txs_i;
            for (int i = 0; i < N; i++) full[i] = (slot_q[i].size() == W);
            hs = m_v && bus.pkt_ready_i;
            ld = (!m_v || bus.pkt_ready_i) && (|full);
            g = 0;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && full[(m_last + k) % N]) begin
                    g = (m_last + k) % N;
                    found = 1;
                end
            end
            nisr = m_isr;
            for (int i = 0; i < N; i++) begin
                if (hs && m_src == i) nisr[i] = 1'b1;
                else if (bus.clr_isrs_txc_i[i]) nisr[i] = 1'b0;
            end
            @(posedge clk);
            m_isr = nisr;
            for (int i = 0; i < N; i++)
                if (v[i] && !full[i]) slot_q[i].push_back(d[i]);
            if (ld) begin
                for (int w = 0; w < W; w++) m_data[w*32 +: 32] = slot_q[g][w];
                slot_q[g].delete();
                m_src  = g;
                m_last = g;
                m_v    = 1'b1;
            end else if (hs) begin
                m_v = 1'b0;
            end
        end
        #1;
        checkAll();
    endtask

    task automatic idleInputs();
        bus.txs_v_i        = '0;
        bus.clr_isrs_txc_i = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        applyStimulus();
        reset = 1'b0;
    endtask

    logic [31:0] words [4];
    int          src_hist [$];
    int          repeats;

    initial begin
        reset = 1'b1;
        bus.txs_i = '0;
        bus.pkt_ready_i = 1'b1;
        idleInputs();
        modelReset();
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_tdfv0", PW'(bus.tdfv_o[0]), PW'(4));
        checkOutput("rst_ready", PW'(bus.txs_ready_o), PW'(2'b11));
        checkOutput("rst_pkt_v", PW'(bus.pkt_v_o), PW'(0));

        $display("[TB] single packet on slot 0");
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int w = 0; w < 4; w++) begin
            bus.txs_i[0] = words[w];
            bus.txs_v_i  = 2'b01;
            applyStimulus();
            checkOutput("single_tdfv", PW'(bus.tdfv_o[0]), PW'(3 - w));
        end
        idleInputs();
        applyStimulus();
        checkOutput("single_v", PW'(bus.pkt_v_o), PW'(1));
        checkOutput("single_pkt", bus.pkt_o, 128'h00000044_00000033_00000022_00000011);
        checkOutput("single_src", PW'(bus.pkt_src_o), PW'(0));
        applyStimulus();
        checkOutput("single_isr", PW'(bus.isr_txc_o[0]), PW'(1));
        checkOutput("single_tdfv_back", PW'(bus.tdfv_o[0]), PW'(4));

        $display("[TB] isr clear alone");
        bus.clr_isrs_txc_i = 2'b01;
        applyStimulus();
        idleInputs();
        checkOutput("isr_clear", PW'(bus.isr_txc_o[0]), PW'(0));

        $display("[TB] simultaneous full");
        doReset();
        for (int w = 0; w < 4; w++) begin
            bus.txs_i[0] = 32'h100 + w;
            bus.txs_i[1] = 32'h200 + w;
            bus.txs_v_i  = 2'b11;
            applyStimulus();
        end
        idleInputs();
        applyStimulus();
        checkOutput("simul_first_src", PW'(bus.pkt_src_o), PW'(0));
        applyStimulus();
        checkOutput("simul_second_v", PW'(bus.pkt_v_o), PW'(1));
        checkOutput("simul_second_src", PW'(bus.pkt_src_o), PW'(1));
        checkOutput("simul_second_pkt", bus.pkt_o, 128'h00000203_00000202_00000201_00000200);
        applyStimulus();
        checkOutput("simul_drained", PW'(bus.pkt_v_o), PW'(0));

        $display("[TB] backpressure");
        doReset();
        bus.pkt_ready_i = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < 4; w++) begin
                bus.txs_i[0] = 32'h300 + 16 * p + w;
                bus.txs_v_i  = 2'b01;
                applyStimulus();
            end
            idleInputs();
            applyStimulus();
        end
        applyStimulus();
        checkOutput("bp_ready0", PW'(bus.txs_ready_o[0]), PW'(0));
        checkOutput("bp_tdfv0", PW'(bus.tdfv_o[0]), PW'(0));
        checkOutput("bp_hold_pkt", bus.pkt_o, 128'h00000303_00000302_00000301_00000300);
        bus.pkt_ready_i    = 1'b1;
        bus.clr_isrs_txc_i = 2'b01;
        applyStimulus();
        bus.pkt_ready_i = 1'b0;
        idleInputs();
        checkOutput("bp_second_v", PW'(bus.pkt_v_o), PW'(1));
        checkOutput("bp_second_pkt", bus.pkt_o, 128'h00000313_00000312_00000311_00000310);
        checkOutput("isr_set_wins", PW'(bus.isr_txc_o[0]), PW'(1));
        bus.pkt_ready_i = 1'b1;
        applyStimulus();

        $display("[TB] fairness");
        doReset();
        src_hist.delete();
        for (int c = 0; c < 40; c++) begin
            bus.txs_i[0] = $urandom();
            bus.txs_i[1] = $urandom();
            bus.txs_v_i  = 2'b11;
            if (bus.pkt_v_o && bus.pkt_ready_i) src_hist.push_back(int'(bus.pkt_src_o));
            applyStimulus();
        end
        idleInputs();
        repeats = 0;
        for (int k = 1; k < src_hist.size(); k++)
            if (src_hist[k] == src_hist[k-1]) repeats++;
        checkOutput("fair_repeats", PW'(repeats), PW'(0));
        checkOutput("fair_count", PW'(src_hist.size() >= 8), PW'(1));

        $display("[TB] reset mid-packet");
        doReset();
        bus.pkt_ready_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            bus.txs_i[0] = 32'h500 + w;
            bus.txs_v_i  = 2'b01;
            applyStimulus();
        end
        for (int w = 0; w < 2; w++) begin
            bus.txs_i[1] = 32'h600 + w;
            bus.txs_v_i  = 2'b10;
            applyStimulus();
        end
        checkOutput("mid_pre_v", PW'(bus.pkt_v_o), PW'(1));
        checkOutput("mid_pre_tdfv1", PW'(bus.tdfv_o[1]), PW'(2));
        doReset();
        checkOutput("mid_v", PW'(bus.pkt_v_o), PW'(0));
        checkOutput("mid_tdfv1", PW'(bus.tdfv_o[1]), PW'(4));
        checkOutput("mid_isr", PW'(bus.isr_txc_o), PW'(0));
        bus.pkt_ready_i = 1'b1;
        for (int w = 0; w < 4; w++) begin
            bus.txs_i[1] = 32'hA1 + w;
            bus.txs_v_i  = 2'b10;
            applyStimulus();
        end
        idleInputs();
        applyStimulus();
        checkOutput("mid_new_pkt", bus.pkt_o, 128'h000000A4_000000A3_000000A2_000000A1);
        checkOutput("mid_new_src", PW'(bus.pkt_src_o), PW'(1));

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) bus.txs_i[i] = $urandom();
            bus.txs_v_i        = N'($urandom_range(0, (1 << N) - 1));
            bus.pkt_ready_i    = ($urandom_range(0, 9) < 6);
            bus.clr_isrs_txc_i = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            reset              = ($urandom_range(0, 199) == 0);
            applyStimulus();
        end
        reset = 1'b0;
        idleInputs();
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
